occupancy_ray_tracer: RTL and testbench
=======================================

OCCUPANCY_RAY_TRACER -- requirements
Module: occupancy_ray_tracer

Interface
REQ-001 SHALL have parameter X_WIDTH, default 5, grid column index width.
REQ-002 SHALL have parameter Y_WIDTH, default 4, grid row index width.
REQ-003 clock  in  1  single clock; all state updates on posedge clock.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  request a ray; sampled only when ready=1.
REQ-006 x0 / y0  in  X_WIDTH / Y_WIDTH  robot (ray origin) cell, sampled with start.
REQ-007 x1 / y1  in  X_WIDTH / Y_WIDTH  laser endpoint cell, sampled with start.
REQ-008 hit  in  1  1 = laser return at endpoint (occupied); 0 = max-range, endpoint free; sampled with start.
REQ-009 abort  in  1  synchronous cancel of the current ray.
REQ-010 ready  out  1  high only in IDLE.
REQ-011 cell_x / cell_y  out  X_WIDTH / Y_WIDTH  current cell index, drives the grid datapath x/y.
REQ-012 write_enable  out  1  one-cycle grid write strobe.
REQ-013 cell_is_free  out  1  1 = decrement cell (free), 0 = increment (occupied).
REQ-014 done  out  1  one-cycle pulse at ray completion.

Function
REQ-015 FSM states SHALL be IDLE, INIT, READ, WRITE, DONE; all outputs decoded from registered state and registered coordinates (Moore, glitch-free).
REQ-016 IDLE: on start=1, latch x0,y0,x1,y1,hit; go INIT. Otherwise stay.
REQ-017 INIT (1 cycle): compute dx=|x1-x0|, dy=-|y1-y0|, sx/sy=+1 or -1 by sign, err=dx+dy; current cell=(x0,y0); go READ.
REQ-018 READ (1 cycle): present cell on cell_x/cell_y, write_enable=0, allowing the grid RAM one cycle of read latency.
REQ-019 WRITE (1 cycle): same cell, write_enable=1; cell_is_free=1 for every cell except the endpoint, where cell_is_free=~hit.
REQ-020 WRITE, current cell != endpoint: Bresenham step: e2=2*err; if e2>=dy {err+=dy; x+=sx}; if e2<=dx {err+=dx; y+=sy}; both use the pre-update e2; go READ.
REQ-021 WRITE, current cell == endpoint: go DONE. DONE: done=1 for one cycle, then IDLE.
REQ-022 Arithmetic: dx, dy 7-bit signed; err 8-bit signed; e2 9-bit signed; no truncation for any in-grid endpoints.
REQ-023 Coordinates SHALL never wrap: the trace ends exactly at (x1,y1) and never steps past the grid edge.
REQ-024 Cells written = max(dx,|dy|)+1 = N; start accepted at cycle 0 -> done=1 at cycle 2N+2, ready=1 at cycle 2N+3.
REQ-025 start while ready=0 SHALL be ignored; no queuing.
REQ-026 Degenerate ray (x0,y0)==(x1,y1): exactly one READ/WRITE pair, cell_is_free=~hit.
REQ-027 abort=1 in any non-IDLE state: write_enable forced 0 that cycle; next state IDLE; done not asserted.
REQ-028 abort in IDLE SHALL be ignored; abort together with start in IDLE gives priority to abort (start ignored).

Reset
REQ-029 reset_n=0 SHALL force state IDLE immediately; ready=1; write_enable=0, done=0, cell_is_free=0, cell_x=0, cell_y=0; internal registers 0.
REQ-030 Reset asserted mid-ray SHALL discard the ray with no further writes; no done pulse after release.

Structure
REQ-031 Shared package occupancy_pkg SHALL hold X_WIDTH/Y_WIDTH defaults and the ray_state_t enum.
REQ-032 Bresenham step arithmetic (REQ-020) SHALL live in one combinational sub-module, ray_step; FSM and registers in occupancy_ray_tracer.

Verification
REQ-033 (0,0)->(3,0), hit=1 -> writes (0,0),(1,0),(2,0) free, (3,0) occupied; 4 write_enable pulses; done at cycle 10.
REQ-034 (2,1)->(4,6), hit=1 -> cell order (2,1),(2,2),(3,3),(3,4),(4,5),(4,6); last occupied; done at cycle 14.
REQ-035 (31,15)->(0,15), hit=0 -> 32 free writes, x descending 31..0, no wrap; done at cycle 66.
REQ-036 (5,5)->(5,5), hit=0 -> single free write at (5,5); done at cycle 4.
REQ-037 start pulsed mid-ray -> ignored, first ray unchanged; abort in a WRITE cycle -> no write that cycle, ready=1 next cycle, no done.
REQ-038 reset_n low during READ of cell 2 -> outputs at reset values immediately; no writes or done after release until new start.

Source files
------------

// File: rtl/occupancy_pkg.sv
// Shared defaults and state encoding for the occupancy-grid ray tracer.
package occupancy_pkg;

    localparam int X_WIDTH = 5;
    localparam int Y_WIDTH = 4;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        READ,
        WRITE,
        DONE
    } ray_state_t;

endpackage

// File: rtl/occupancy_ray_tracer_if.sv
// Ray request / grid-update bus between the requester (master) and the tracer (slave).
interface occupancy_ray_tracer_if #(
    parameter int X_WIDTH = occupancy_pkg::X_WIDTH,
    parameter int Y_WIDTH = occupancy_pkg::Y_WIDTH
);

    logic               start;
    logic [X_WIDTH-1:0] x0;
    logic [Y_WIDTH-1:0] y0;
    logic [X_WIDTH-1:0] x1;
    logic [Y_WIDTH-1:0] y1;
    logic               hit;
    logic               abort;
    logic               ready;
    logic [X_WIDTH-1:0] cell_x;
    logic [Y_WIDTH-1:0] cell_y;
    logic               write_enable;
    logic               cell_is_free;
    logic               done;

    modport master (
        output start, x0, y0, x1, y1, hit, abort,
        input  ready, cell_x, cell_y, write_enable, cell_is_free, done
    );

    modport slave (
        input  start, x0, y0, x1, y1, hit, abort,
        output ready, cell_x, cell_y, write_enable, cell_is_free, done
    );

endinterface

// File: rtl/ray_step.sv
// One combinational Bresenham step: both decisions use the pre-update doubled error.
module ray_step #(
    parameter int X_WIDTH   = occupancy_pkg::X_WIDTH,
    parameter int Y_WIDTH   = occupancy_pkg::Y_WIDTH,
    parameter int D_WIDTH   = 7,
    parameter int ERR_WIDTH = 8,
    parameter int E2_WIDTH  = 9
) (
    input  logic                        [X_WIDTH-1:0]   x,
    input  logic                        [Y_WIDTH-1:0]   y,
    input  logic signed                 [ERR_WIDTH-1:0] err,
    input  logic signed                 [D_WIDTH-1:0]   dx,
    input  logic signed                 [D_WIDTH-1:0]   dy,
    input  logic                                        x_neg,
    input  logic                                        y_neg,
    output logic                        [X_WIDTH-1:0]   next_x,
    output logic                        [Y_WIDTH-1:0]   next_y,
    output logic signed                 [ERR_WIDTH-1:0] next_err
);

    logic signed [E2_WIDTH-1:0] err_ext;
    logic signed [E2_WIDTH-1:0] e2;
    logic signed [E2_WIDTH-1:0] dx_ext;
    logic signed [E2_WIDTH-1:0] dy_ext;
    logic                       step_x;
    logic                       step_y;

    always_comb begin
        err_ext  = E2_WIDTH'(err);
        e2       = {err_ext[E2_WIDTH-2:0], 1'b0};
        dx_ext   = E2_WIDTH'(dx);
        dy_ext   = E2_WIDTH'(dy);
        step_x   = (e2 >= dy_ext);
        step_y   = (e2 <= dx_ext);

        next_err = err;
        next_x   = x;
        next_y   = y;
        if (step_x) begin
            next_err = next_err + ERR_WIDTH'(dy);
            next_x   = x_neg ? (x - X_WIDTH'(1)) : (x + X_WIDTH'(1));
        end
        if (step_y) begin
            next_err = next_err + ERR_WIDTH'(dx);
            next_y   = y_neg ? (y - Y_WIDTH'(1)) : (y + Y_WIDTH'(1));
        end
    end

endmodule

// File: rtl/occupancy_ray_tracer.sv
// Walks a Bresenham ray from robot cell to laser endpoint, issuing a read/write pair per cell
// to an occupancy grid: free cells are decremented, the endpoint follows the hit flag.
module occupancy_ray_tracer #(
    parameter int X_WIDTH = occupancy_pkg::X_WIDTH,
    parameter int Y_WIDTH = occupancy_pkg::Y_WIDTH
) (
    input  logic                 clock,
    input  logic                 reset_n,
    occupancy_ray_tracer_if.slave bus
);

    import occupancy_pkg::*;

    localparam int D_WIDTH   = ((X_WIDTH > Y_WIDTH) ? X_WIDTH : Y_WIDTH) + 2;
    localparam int ERR_WIDTH = D_WIDTH + 1;
    localparam int E2_WIDTH  = D_WIDTH + 2;

    ray_state_t                  state;
    logic        [X_WIDTH-1:0]   cur_x;
    logic        [Y_WIDTH-1:0]   cur_y;
    logic        [X_WIDTH-1:0]   end_x;
    logic        [Y_WIDTH-1:0]   end_y;
    logic                        hit_q;
    logic                        x_neg;
    logic                        y_neg;
    logic signed [D_WIDTH-1:0]   dx;
    logic signed [D_WIDTH-1:0]   dy;
    logic signed [ERR_WIDTH-1:0] err;

    logic signed [D_WIDTH-1:0]   x_diff;
    logic signed [D_WIDTH-1:0]   y_diff;
    logic signed [D_WIDTH-1:0]   abs_dx;
    logic signed [D_WIDTH-1:0]   abs_dy;
    logic        [X_WIDTH-1:0]   next_x;
    logic        [Y_WIDTH-1:0]   next_y;
    logic signed [ERR_WIDTH-1:0] next_err;
    logic                        at_end;

    // Origin is already held in cur_x/cur_y while in INIT, so deltas come from the registers.
    always_comb begin
        x_diff = $signed(D_WIDTH'(end_x)) - $signed(D_WIDTH'(cur_x));
        y_diff = $signed(D_WIDTH'(end_y)) - $signed(D_WIDTH'(cur_y));
        abs_dx = x_diff[D_WIDTH-1] ? -x_diff : x_diff;
        abs_dy = y_diff[D_WIDTH-1] ? -y_diff : y_diff;
        at_end = (cur_x == end_x) && (cur_y == end_y);
    end

    ray_step #(
        .X_WIDTH  (X_WIDTH),
        .Y_WIDTH  (Y_WIDTH),
        .D_WIDTH  (D_WIDTH),
        .ERR_WIDTH(ERR_WIDTH),
        .E2_WIDTH (E2_WIDTH)
    ) u_step (
        .x       (cur_x),
        .y       (cur_y),
        .err     (err),
        .dx      (dx),
        .dy      (dy),
        .x_neg   (x_neg),
        .y_neg   (y_neg),
        .next_x  (next_x),
        .next_y  (next_y),
        .next_err(next_err)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cur_x <= '0;
            cur_y <= '0;
            end_x <= '0;
            end_y <= '0;
            hit_q <= 1'b0;
            x_neg <= 1'b0;
            y_neg <= 1'b0;
            dx    <= '0;
            dy    <= '0;
            err   <= '0;
        end else if (state != IDLE && bus.abort) begin
            state <= IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start && !bus.abort) begin
                        cur_x <= bus.x0;
                        cur_y <= bus.y0;
                        end_x <= bus.x1;
                        end_y <= bus.y1;
                        hit_q <= bus.hit;
                        state <= INIT;
                    end
                end
                INIT: begin
                    dx    <= abs_dx;
                    dy    <= -abs_dy;
                    x_neg <= x_diff[D_WIDTH-1];
                    y_neg <= y_diff[D_WIDTH-1];
                    err   <= ERR_WIDTH'(abs_dx) - ERR_WIDTH'(abs_dy);
                    state <= READ;
                end
                READ: begin
                    state <= WRITE;
                end
                WRITE: begin
                    if (at_end) begin
                        state <= DONE;
                    end else begin
                        cur_x <= next_x;
                        cur_y <= next_y;
                        err   <= next_err;
                        state <= READ;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Abort must suppress the strobe in the very cycle it arrives, hence the input gating.
    assign bus.ready        = (state == IDLE);
    assign bus.cell_x       = cur_x;
    assign bus.cell_y       = cur_y;
    assign bus.write_enable = (state == WRITE) && !bus.abort;
    assign bus.cell_is_free = (state == WRITE) && (!at_end || !hit_q);
    assign bus.done         = (state == DONE) && !bus.abort;

endmodule

// File: tb/tb_occupancy_ray_tracer.sv
// Scoreboard bench: directed rays push expected writes/done cycles; a negedge monitor pops and compares.
module tb_occupancy_ray_tracer;

    typedef struct {
        int x;
        int y;
        bit free;
    } wr_t;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    occupancy_ray_tracer_if #(.X_WIDTH(5), .Y_WIDTH(4)) bus ();

    occupancy_ray_tracer #(.X_WIDTH(5), .Y_WIDTH(4)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int  cyc = 0;
    wr_t wr_q[$];
    int  done_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    wr_t exp_wr;
    int  exp_done;

    always @(posedge clock) cyc++;

    function automatic void check(string name, int got, int expv);
        n_checks++;
        if (got != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle count %0d)", name, got, expv, cyc);
        end
    endfunction

    always @(negedge clock) begin
        if (reset_n) begin
            if (bus.write_enable === 1'b1) begin
                if (wr_q.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    exp_wr = wr_q.pop_front();
                    check("write_x", int'(bus.cell_x), exp_wr.x);
                    check("write_y", int'(bus.cell_y), exp_wr.y);
                    check("write_free", int'(bus.cell_is_free), int'(exp_wr.free));
                end
            end
            if (bus.done === 1'b1) begin
                if (done_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_done = done_q.pop_front();
                    check("done_cycle", cyc, exp_done);
                end
            end
        end
    end

    task automatic tick(int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic push_wr(int x, int y, bit free);
        wr_t w;
        w.x = x;
        w.y = y;
        w.free = free;
        wr_q.push_back(w);
    endtask

    task automatic drive(int x0, int y0, int x1, int y1, bit hit);
        bus.x0  = 5'(x0);
        bus.y0  = 4'(y0);
        bus.x1  = 5'(x1);
        bus.y1  = 4'(y1);
        bus.hit = hit;
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_ready"}, int'(bus.ready), 1);
        check({tag, "_write_enable"}, int'(bus.write_enable), 0);
        check({tag, "_done"}, int'(bus.done), 0);
        check({tag, "_cell_is_free"}, int'(bus.cell_is_free), 0);
        check({tag, "_cell_x"}, int'(bus.cell_x), 0);
        check({tag, "_cell_y"}, int'(bus.cell_y), 0);
    endtask

    task automatic run_ray(int x0, int y0, int x1, int y1, bit hit, int n, bit inject);
        int t0;
        int k;
        drive(x0, y0, x1, y1, hit);
        bus.start = 1'b1;
        t0 = cyc;
        done_q.push_back(t0 + 2 * n + 2);
        tick();
        bus.start = 1'b0;
        if (inject) begin
            tick(3);
            drive(9, 9, 10, 9, 1'b0);
            bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
        end
        k = 0;
        while (bus.ready !== 1'b1 && k < 200) begin
            tick();
            k++;
        end
        check("ready_cycle", cyc - t0, 2 * n + 3);
        check("writes_outstanding", wr_q.size(), 0);
        check("done_outstanding", done_q.size(), 0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int t0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        drive(0, 0, 0, 0, 1'b0);
        tick(2);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        tick();

        // (0,0)->(3,0) hit
        push_wr(0, 0, 1); push_wr(1, 0, 1); push_wr(2, 0, 1); push_wr(3, 0, 0);
        run_ray(0, 0, 3, 0, 1'b1, 4, 1'b0);

        // (2,1)->(4,6) hit
        push_wr(2, 1, 1); push_wr(2, 2, 1); push_wr(3, 3, 1);
        push_wr(3, 4, 1); push_wr(4, 5, 1); push_wr(4, 6, 0);
        run_ray(2, 1, 4, 6, 1'b1, 6, 1'b0);

        // (31,15)->(0,15) max range: x walks down to the edge without wrapping
        for (int x = 31; x >= 0; x--) push_wr(x, 15, 1);
        run_ray(31, 15, 0, 15, 1'b0, 32, 1'b0);

        // degenerate ray
        push_wr(5, 5, 1);
        run_ray(5, 5, 5, 5, 1'b0, 1, 1'b0);

        // reverse direction in both axes, no hit
        push_wr(4, 6, 1); push_wr(4, 5, 1); push_wr(3, 4, 1);
        push_wr(3, 3, 1); push_wr(2, 2, 1); push_wr(2, 1, 1);
        run_ray(4, 6, 2, 1, 1'b0, 6, 1'b0);

        // start pulsed while busy must not disturb the ray
        push_wr(0, 0, 1); push_wr(1, 0, 1); push_wr(2, 0, 1); push_wr(3, 0, 0);
        run_ray(0, 0, 3, 0, 1'b1, 4, 1'b1);

        // abort in the second WRITE cycle (cycle 5)
        push_wr(2, 1, 1);
        drive(2, 1, 4, 6, 1'b1);
        bus.start = 1'b1;
        t0 = cyc;
        tick();
        bus.start = 1'b0;
        tick(4);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("abort_ready", int'(bus.ready), 1);
        check("abort_ready_cycle", cyc - t0, 6);
        tick(6);
        check("abort_writes_outstanding", wr_q.size(), 0);

        // abort together with start in IDLE wins
        drive(1, 1, 2, 2, 1'b1);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("abort_start_idle_ready", int'(bus.ready), 1);
        tick(4);
        check("abort_start_idle_still_ready", int'(bus.ready), 1);

        // reset during the READ of cell 2 (cycle 6)
        push_wr(0, 0, 1); push_wr(1, 0, 1);
        drive(0, 0, 3, 0, 1'b1);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick(5);
        check("pre_reset_cell_x", int'(bus.cell_x), 2);
        check("pre_reset_write_enable", int'(bus.write_enable), 0);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midray_reset");
        tick();
        reset_n = 1'b1;
        tick(12);
        check("reset_writes_outstanding", wr_q.size(), 0);
        check("reset_idle_ready", int'(bus.ready), 1);

        // normal operation after reset recovery
        push_wr(5, 5, 0);
        run_ray(5, 5, 5, 5, 1'b1, 1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
